// File: rtl/exception_detect.sv
// Registered RV32I fault detector: fetch/load/store misalignment and out-of-window access flags.
// Decode bit positions are parameters so they can track the controller's one-hot layout.
module exception_detect #(
  parameter logic [31:0] MEM_BASE         = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE         = 32'h0010_0000,
  parameter int          OPCODE_WIDTH     = 7,
  parameter int          OP_LOAD          = 0,
  parameter int          OP_STORE         = 1,
  parameter int          MIKROISLEM_WIDTH = 32,
  parameter int          MK_LB            = 0,
  parameter int          MK_LBU           = 1,
  parameter int          MK_LH            = 2,
  parameter int          MK_LHU           = 3,
  parameter int          MK_LW            = 4,
  parameter int          MK_SB            = 5,
  parameter int          MK_SH            = 6,
  parameter int          MK_SW            = 7
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [31:0]                 pc_i,
  input  logic [31:0]                 memory_addr_i,
  input  logic [OPCODE_WIDTH-1:0]     opcode_i,
  input  logic [MIKROISLEM_WIDTH-1:0] mikro_islem_i,
  output logic                        INSTRUCTION_ADDRESS_MISALIGNED,
  output logic                        INSTRUCTION_ACCESS_FAULT,
  output logic                        LOAD_ADDRESS_MISALIGNED,
  output logic                        LOAD_ACCESS_FAULT,
  output logic                        STORE_ADDRESS_MISALIGNED,
  output logic                        STORE_ACCESS_FAULT
);

  // 33-bit compare so a window ending at 2^32 cannot wrap.
  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, MEM_BASE};
    return ({1'b0, a} >= {1'b0, MEM_BASE}) && (off < {1'b0, MEM_SIZE});
  endfunction

  logic is_load, is_store;
  logic half_ld, word_ld, half_st, word_st;
  logic pc_ok, addr_ok;
  logic iam_d, iaf_d, lam_d, laf_d, sam_d, saf_d;

  always_comb begin
    is_load  = opcode_i[OP_LOAD];
    is_store = opcode_i[OP_STORE];
    half_ld  = mikro_islem_i[MK_LH] | mikro_islem_i[MK_LHU];
    word_ld  = mikro_islem_i[MK_LW];
    half_st  = mikro_islem_i[MK_SH];
    word_st  = mikro_islem_i[MK_SW];
    pc_ok    = in_range(pc_i);
    addr_ok  = in_range(memory_addr_i);

    iam_d = (pc_i[1:0] != 2'b00);
    iaf_d = !pc_ok;
    // Byte accesses never misalign, so LB/LBU/SB contribute nothing here.
    lam_d = is_load  && ((half_ld && memory_addr_i[0]) || (word_ld && (memory_addr_i[1:0] != 2'b00)));
    laf_d = is_load  && !addr_ok;
    sam_d = is_store && ((half_st && memory_addr_i[0]) || (word_st && (memory_addr_i[1:0] != 2'b00)));
    saf_d = is_store && !addr_ok;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      INSTRUCTION_ADDRESS_MISALIGNED <= 1'b0;
      INSTRUCTION_ACCESS_FAULT       <= 1'b0;
      LOAD_ADDRESS_MISALIGNED        <= 1'b0;
      LOAD_ACCESS_FAULT              <= 1'b0;
      STORE_ADDRESS_MISALIGNED       <= 1'b0;
      STORE_ACCESS_FAULT             <= 1'b0;
    end else begin
      INSTRUCTION_ADDRESS_MISALIGNED <= iam_d;
      INSTRUCTION_ACCESS_FAULT       <= iaf_d;
      LOAD_ADDRESS_MISALIGNED        <= lam_d;
      LOAD_ACCESS_FAULT              <= laf_d;
      STORE_ADDRESS_MISALIGNED       <= sam_d;
      STORE_ACCESS_FAULT             <= saf_d;
    end
  end

endmodule

// File: tb/tb_exception_detect.sv
// Scoreboarded random bench for exception_detect against a size/modulo reference model.
// Flag vectors are packed {IAM, IAF, LAM, LAF, SAM, SAF}.
module tb_exception_detect;

  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] MEM_SIZE = 32'h0010_0000;
  localparam int OPW = 7, OP_LOAD = 0, OP_STORE = 1;
  localparam int MKW = 32;
  localparam int MK_LB = 0, MK_LBU = 1, MK_LH = 2, MK_LHU = 3, MK_LW = 4;
  localparam int MK_SB = 5, MK_SH = 6, MK_SW = 7;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic [31:0]    pc_i = '0;
  logic [31:0]    memory_addr_i = '0;
  logic [OPW-1:0] opcode_i = '0;
  logic [MKW-1:0] mikro_islem_i = '0;
  logic iam, iaf, lam, laf, sam, saf;

  logic [5:0]  expQ[$];
  string       nameQ[$];
  int          vectorCount = 0;
  int          missCount = 0;

  exception_detect #(
    .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE),
    .OPCODE_WIDTH(OPW), .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE),
    .MIKROISLEM_WIDTH(MKW),
    .MK_LB(MK_LB), .MK_LBU(MK_LBU), .MK_LH(MK_LH), .MK_LHU(MK_LHU), .MK_LW(MK_LW),
    .MK_SB(MK_SB), .MK_SH(MK_SH), .MK_SW(MK_SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .memory_addr_i(memory_addr_i),
    .opcode_i(opcode_i), .mikro_islem_i(mikro_islem_i),
    .INSTRUCTION_ADDRESS_MISALIGNED(iam), .INSTRUCTION_ACCESS_FAULT(iaf),
    .LOAD_ADDRESS_MISALIGNED(lam), .LOAD_ACCESS_FAULT(laf),
    .STORE_ADDRESS_MISALIGNED(sam), .STORE_ACCESS_FAULT(saf)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit inWindow(input logic [31:0] a);
    longint unsigned la, lo, hi;
    la = longint'(a);
    lo = longint'(MEM_BASE);
    hi = lo + longint'(MEM_SIZE);
    return (la >= lo) && (la < hi);
  endfunction

  // Each access kind is a (decode bit, access size) pair; misaligned means addr mod size != 0.
  function automatic logic [5:0] model(input logic rst, input logic [31:0] pc,
                                       input logic [31:0] addr, input logic [OPW-1:0] op,
                                       input logic [MKW-1:0] mk);
    int ldIdx[5] = '{MK_LB, MK_LBU, MK_LH, MK_LHU, MK_LW};
    int ldSz[5]  = '{1, 1, 2, 2, 4};
    int stIdx[3] = '{MK_SB, MK_SH, MK_SW};
    int stSz[3]  = '{1, 2, 4};
    bit eIam, eIaf, eLam, eLaf, eSam, eSaf;
    if (rst) return 6'b0;
    eIam = (pc % 4) != 0;
    eIaf = !inWindow(pc);
    eLam = 0;
    eSam = 0;
    for (int k = 0; k < 5; k++)
      if (mk[ldIdx[k]] && (addr % ldSz[k]) != 0) eLam = 1;
    for (int k = 0; k < 3; k++)
      if (mk[stIdx[k]] && (addr % stSz[k]) != 0) eSam = 1;
    eLam = eLam && op[OP_LOAD];
    eSam = eSam && op[OP_STORE];
    eLaf = op[OP_LOAD] && !inWindow(addr);
    eSaf = op[OP_STORE] && !inWindow(addr);
    return {eIam, eIaf, eLam, eLaf, eSam, eSaf};
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the flags expected after the next rise.
  task automatic applyStimulus(input string nm, input logic rst, input logic [31:0] pc,
                               input logic [31:0] addr, input logic [OPW-1:0] op,
                               input logic [MKW-1:0] mk);
    @(negedge clk_i);
    rst_i = rst;
    pc_i = pc;
    memory_addr_i = addr;
    opcode_i = op;
    mikro_islem_i = mk;
    expQ.push_back(model(rst, pc, addr, op, mk));
    nameQ.push_back(nm);
  endtask

  task automatic checkOutput(input string nm, input logic [5:0] act, input logic [5:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got flags %b, expected %b", nm, act, exp);
    end
  endtask

  // Monitor: flags are valid every cycle, one edge after the inputs were driven.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (expQ.size() > 0) checkOutput(nameQ.pop_front(), {iam, iaf, lam, laf, sam, saf}, expQ.pop_front());
    end
  end

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 4))
      0: return MEM_BASE + ($urandom_range(0, 15));
      1: return MEM_BASE + MEM_SIZE - 32'($urandom_range(1, 8));
      2: return MEM_BASE + MEM_SIZE + 32'($urandom_range(0, 7));
      3: return MEM_BASE - 32'($urandom_range(1, 8));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [MKW-1:0] mk;
    logic [OPW-1:0] op;
    int waitCycles;

    applyStimulus("reset", 1'b1, 32'h8000_0000, 32'h0, '0, '0);
    applyStimulus("idle", 1'b0, 32'h8000_0000, 32'h0, '0, '0);
    applyStimulus("pc_misaligned", 1'b0, 32'h8000_0002, 32'h0, '0, '0);
    applyStimulus("pc_out_of_range", 1'b0, 32'h7000_0000, 32'h0, '0, '0);
    applyStimulus("pc_last_word", 1'b0, MEM_BASE + MEM_SIZE - 4, 32'h0, '0, '0);
    applyStimulus("pc_past_end", 1'b0, MEM_BASE + MEM_SIZE, 32'h0, '0, '0);
    applyStimulus("lh_misaligned", 1'b0, 32'h8000_0000, 32'h8000_0001,
                  OPW'(1) << OP_LOAD, MKW'(1) << MK_LH);
    applyStimulus("load_fault", 1'b0, 32'h8000_0000, 32'h7000_0000,
                  OPW'(1) << OP_LOAD, (MKW'(1) << MK_LH) | (MKW'(1) << MK_LW));
    applyStimulus("load_store_misaligned", 1'b0, 32'h8000_0000, 32'h8000_0001,
                  (OPW'(1) << OP_LOAD) | (OPW'(1) << OP_STORE),
                  (MKW'(1) << MK_LH) | (MKW'(1) << MK_LW) | (MKW'(1) << MK_SH));
    applyStimulus("store_fault", 1'b0, 32'h8000_0000, 32'h7000_0000,
                  OPW'(1) << OP_STORE, MKW'(1) << MK_SW);
    applyStimulus("reset_over_faults", 1'b1, 32'h7000_0003, 32'h7000_0001,
                  (OPW'(1) << OP_LOAD) | (OPW'(1) << OP_STORE), MKW'(1) << MK_SW);
    applyStimulus("lb_any_alignment", 1'b0, 32'h8000_0000, 32'h8000_0003,
                  OPW'(1) << OP_LOAD, MKW'(1) << MK_LB);
    applyStimulus("lw_ungated", 1'b0, 32'h8000_0000, 32'h7000_0002, '0, MKW'(1) << MK_LW);
    applyStimulus("sh_half_ok", 1'b0, 32'h8000_0000, 32'h8000_0002,
                  OPW'(1) << OP_STORE, MKW'(1) << MK_SH);
    applyStimulus("sw_half_only", 1'b0, 32'h8000_0000, 32'h8000_0002,
                  OPW'(1) << OP_STORE, MKW'(1) << MK_SW);

    for (int i = 0; i < 400; i++) begin
      op = OPW'($urandom);
      mk = MKW'($urandom) & MKW'($urandom);
      applyStimulus("random", ($urandom_range(0, 29) == 0), randAddr(), randAddr(), op, mk);
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk_i);
      waitCycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      missCount++;
      $display("[TB] FAIL drain: %0d pending expectations, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
